// File: rtl/reg_bank_arbiter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank_arbiter_pkg : owner encoding and default bus widths
// Rev 1.0
// ----------------------------------------------------------------------------
package reg_bank_arbiter_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_A    = 2'b01,
        OWN_B    = 2'b10
    } owner_t;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 2;

endpackage
`default_nettype wire

// File: rtl/reg_bank_arbiter_bank.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank : D-register word storage, async clear, one write + one registered read
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_bank #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata <= '0;
        end else begin
            if (we) begin
                mem[addr] <= wdata;
            end
            // rdata only moves on a read, so it holds between reads
            if (re) begin
                rdata <= mem[addr];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// reg_bank_arbiter : round-robin, burst-limited sharing of a register bank by A and B
// Rev 1.0
// ----------------------------------------------------------------------------
module reg_bank_arbiter
    import reg_bank_arbiter_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int MAX_BURST = 4
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              ReqA,
    input  logic              WeA,
    input  logic [ADDR_W-1:0] AddrA,
    input  logic [DATA_W-1:0] WdataA,
    input  logic              ReqB,
    input  logic              WeB,
    input  logic [ADDR_W-1:0] AddrB,
    input  logic [DATA_W-1:0] WdataB,
    output logic              GntA,
    output logic              GntB,
    output logic [DATA_W-1:0] Rdata,
    output logic              RvalidA,
    output logic              RvalidB
);

    localparam int               CNT_W    = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    owner_t           owner, owner_nxt;
    owner_t           last, last_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;

    logic              acc_a, acc_b;
    logic              bank_we, bank_re;
    logic [ADDR_W-1:0] bank_addr;
    logic [DATA_W-1:0] bank_wdata;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            owner <= OWN_NONE;
            last  <= OWN_B;
            cnt   <= '0;
        end else begin
            owner <= owner_nxt;
            last  <= last_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = '0;
        case (owner)
            OWN_NONE: begin
                if (ReqA && ReqB) begin
                    owner_nxt = (last == OWN_A) ? OWN_B : OWN_A;
                end else if (ReqA) begin
                    owner_nxt = OWN_A;
                end else if (ReqB) begin
                    owner_nxt = OWN_B;
                end
            end
            OWN_A: begin
                if (ReqA && cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (ReqA) begin
                    owner_nxt = ReqB ? OWN_B : OWN_A;
                end else begin
                    owner_nxt = ReqB ? OWN_B : OWN_NONE;
                end
            end
            OWN_B: begin
                if (ReqB && cnt != CNT_LAST) begin
                    cnt_nxt = cnt + CNT_W'(1);
                end else if (ReqB) begin
                    owner_nxt = ReqA ? OWN_A : OWN_B;
                end else begin
                    owner_nxt = ReqA ? OWN_A : OWN_NONE;
                end
            end
            default: owner_nxt = OWN_NONE;
        endcase
        // Staying put leaves last unchanged, so this only records new grants
        if (owner_nxt != OWN_NONE) begin
            last_nxt = owner_nxt;
        end
    end

    assign GntA = (owner == OWN_A);
    assign GntB = (owner == OWN_B);

    assign acc_a      = GntA && ReqA;
    assign acc_b      = GntB && ReqB;
    assign bank_we    = (acc_a && WeA) || (acc_b && WeB);
    assign bank_re    = (acc_a && !WeA) || (acc_b && !WeB);
    assign bank_addr  = acc_b ? AddrB : AddrA;
    assign bank_wdata = acc_b ? WdataB : WdataA;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            RvalidA <= 1'b0;
            RvalidB <= 1'b0;
        end else begin
            RvalidA <= acc_a && !WeA;
            RvalidB <= acc_b && !WeB;
        end
    end

    reg_bank #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_bank (
        .clk   (Clk),
        .rst   (Reset),
        .we    (bank_we),
        .re    (bank_re),
        .addr  (bank_addr),
        .wdata (bank_wdata),
        .rdata (Rdata)
    );

endmodule
`default_nettype wire
